// File: rtl/sram_pkg.sv
// Shared state, request types and default widths for the SRAM arbiter.
package sram_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef struct packed {
        logic                   we;
        logic [1:0]             be;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; history only advances when a grant is taken.
module rr_arbiter2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req0_i,
    input  logic req1_i,
    input  logic update_i,
    output logic valid_o,
    output logic grant_o
);

    logic lastGrant_q;
    logic lastGrant_d;

    // On a tie the port that was not served last time wins.
    always_comb begin
        valid_o = req0_i | req1_i;
        grant_o = 1'b0;
        if (req0_i && req1_i) begin
            grant_o = ~lastGrant_q;
        end else if (req1_i) begin
            grant_o = 1'b1;
        end
        lastGrant_d = update_i ? grant_o : lastGrant_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lastGrant_q <= 1'b1;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous SRAM between two requesters with a fixed
// IDLE -> ACCESS (WAIT_CYCLES) -> DONE strobe sequence; all pins registered.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [1:0]        be0,
    input  logic [1:0]        be1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Data
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    req_t              req_q, req_d;
    req_t              winner;
    logic              grant_q, grant_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              ce_q, ce_d;
    logic              oe_q, oe_d;
    logic              we_q, we_d;
    logic              ub_q, ub_d;
    logic              lb_q, lb_d;
    logic              drive_q, drive_d;

    logic arbValid;
    logic arbGrant;
    logic arbUpdate;

    assign arbUpdate = (state_q == IDLE) && arbValid;

    rr_arbiter2 u_arb (
        .clk_i   (Clk),
        .rst_i   (Reset),
        .req0_i  (req0),
        .req1_i  (req1),
        .update_i(arbUpdate),
        .valid_o (arbValid),
        .grant_o (arbGrant)
    );

    // Strobes are loaded on the edge that enters ACCESS so the pins never
    // see a combinational path from the request inputs.
    always_comb begin
        winner.we    = arbGrant ? we1 : we0;
        winner.be    = arbGrant ? be1 : be0;
        winner.addr  = SRAM_ADDR_W'(arbGrant ? addr1 : addr0);
        winner.wdata = SRAM_DATA_W'(arbGrant ? wdata1 : wdata0);

        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        grant_d  = grant_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ce_d     = ce_q;
        oe_d     = oe_q;
        we_d     = we_q;
        ub_d     = ub_q;
        lb_d     = lb_q;
        drive_d  = drive_q;

        case (state_q)
            IDLE: begin
                if (arbValid) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_LOAD;
                    req_d   = winner;
                    grant_d = arbGrant;
                    ce_d    = 1'b0;
                    oe_d    = winner.we;
                    we_d    = ~winner.we;
                    ub_d    = ~winner.be[1];
                    lb_d    = ~winner.be[0];
                    drive_d = winner.we;
                end
            end
            ACCESS: begin
                ub_d = ~req_q.be[1];
                lb_d = ~req_q.be[0];
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    ce_d    = 1'b1;
                    oe_d    = 1'b1;
                    we_d    = 1'b1;
                    ub_d    = 1'b1;
                    lb_d    = 1'b1;
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                    if (!req_q.we) begin
                        if (grant_q) begin
                            rdata1_d = Data;
                        end else begin
                            rdata0_d = Data;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // Write data was held through this cycle; release for turnaround.
                state_d = IDLE;
                drive_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                ce_d    = 1'b1;
                oe_d    = 1'b1;
                we_d    = 1'b1;
                ub_d    = 1'b1;
                lb_d    = 1'b1;
                drive_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            req_q    <= '0;
            grant_q  <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ce_q     <= 1'b1;
            oe_q     <= 1'b1;
            we_q     <= 1'b1;
            ub_q     <= 1'b1;
            lb_q     <= 1'b1;
            drive_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            grant_q  <= grant_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            ce_q     <= ce_d;
            oe_q     <= oe_d;
            we_q     <= we_d;
            ub_q     <= ub_d;
            lb_q     <= lb_d;
            drive_q  <= drive_d;
        end
    end

    assign Data   = drive_q ? DATA_W'(req_q.wdata) : {DATA_W{1'bz}};
    assign ADDR   = ADDR_W'(req_q.addr);
    assign CE     = ce_q;
    assign OE     = oe_q;
    assign WE     = we_q;
    assign UB     = ub_q;
    assign LB     = lb_q;
    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: one WAIT_CYCLES=2 instance with an SRAM
// model, plus WAIT_CYCLES=1 and 15 instances for latency checks.
module tb_sram_arbiter;

    logic clock;
    logic reset;
    int   testCount;
    int   failCount;

    // Instance A (WAIT_CYCLES = 2)
    logic        aReq0, aReq1, aWe0, aWe1;
    logic [1:0]  aBe0, aBe1;
    logic [19:0] aAddr0, aAddr1;
    logic [15:0] aWdata0, aWdata1;
    logic        aAck0, aAck1;
    logic [15:0] aRdata0, aRdata1;
    logic        aCe, aUb, aLb, aOe, aWeN;
    logic [19:0] aAddr;
    wire  [15:0] aData;
    logic [15:0] memA [0:255];

    // Instances B (WAIT_CYCLES = 1) and C (WAIT_CYCLES = 15)
    logic        bReq0, cReq0, tieReq1, tieWe;
    logic [1:0]  tieBe;
    logic [19:0] bAddr0, cAddr0, tieAddr;
    logic [15:0] tieWdata;
    logic        bAck0, bAck1, cAck0, cAck1;
    logic [15:0] bRdata0, bRdata1, cRdata0, cRdata1;
    logic        bCe, bUb, bLb, bOe, bWeN, cCe, cUb, cLb, cOe, cWeN;
    logic [19:0] bAddr, cAddr;
    wire  [15:0] bData, cData;

    typedef struct {
        int          ackCycle;
        int          ceLow;
        int          oeLow;
        int          weLow;
        int          ubLow;
        int          lbLow;
        int          otherAcks;
        logic        ceAtAck;
        logic [15:0] dataAtAck;
        logic        ackAfter;
        logic        drivenAfter;
    } obs_t;

    sram_arbiter #(.WAIT_CYCLES(2)) dutA (
        .Clk(clock), .Reset(reset),
        .req0(aReq0), .req1(aReq1), .we0(aWe0), .we1(aWe1),
        .be0(aBe0), .be1(aBe1), .addr0(aAddr0), .addr1(aAddr1),
        .wdata0(aWdata0), .wdata1(aWdata1),
        .ack0(aAck0), .ack1(aAck1), .rdata0(aRdata0), .rdata1(aRdata1),
        .CE(aCe), .UB(aUb), .LB(aLb), .OE(aOe), .WE(aWeN),
        .ADDR(aAddr), .Data(aData)
    );

    sram_arbiter #(.WAIT_CYCLES(1)) dutB (
        .Clk(clock), .Reset(reset),
        .req0(bReq0), .req1(tieReq1), .we0(tieWe), .we1(tieWe),
        .be0(tieBe), .be1(tieBe), .addr0(bAddr0), .addr1(tieAddr),
        .wdata0(tieWdata), .wdata1(tieWdata),
        .ack0(bAck0), .ack1(bAck1), .rdata0(bRdata0), .rdata1(bRdata1),
        .CE(bCe), .UB(bUb), .LB(bLb), .OE(bOe), .WE(bWeN),
        .ADDR(bAddr), .Data(bData)
    );

    sram_arbiter #(.WAIT_CYCLES(15)) dutC (
        .Clk(clock), .Reset(reset),
        .req0(cReq0), .req1(tieReq1), .we0(tieWe), .we1(tieWe),
        .be0(tieBe), .be1(tieBe), .addr0(cAddr0), .addr1(tieAddr),
        .wdata0(tieWdata), .wdata1(tieWdata),
        .ack0(cAck0), .ack1(cAck1), .rdata0(cRdata0), .rdata1(cRdata1),
        .CE(cCe), .UB(cUb), .LB(cLb), .OE(cOe), .WE(cWeN),
        .ADDR(cAddr), .Data(cData)
    );

    // SRAM models: A is a small byte-writable array, B and C return an address pattern.
    assign aData = (!aCe && !aOe) ? memA[aAddr[7:0]] : 16'hzzzz;
    assign bData = (!bCe && !bOe) ? (16'hA5C3 ^ bAddr[15:0]) : 16'hzzzz;
    assign cData = (!cCe && !cOe) ? (16'hA5C3 ^ cAddr[15:0]) : 16'hzzzz;

    always @(posedge clock) begin
        if (reset) begin
            memA[8'h23] <= 16'hBEEF;
        end else if (!aCe && !aWeN) begin
            if (!aUb) memA[aAddr[7:0]][15:8] <= aData[15:8];
            if (!aLb) memA[aAddr[7:0]][7:0]  <= aData[7:0];
        end
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic port, input logic we, input logic [1:0] be,
                                 input logic [19:0] addr, input logic [15:0] wdata,
                                 output obs_t o);
        o.ackCycle    = -1;
        o.ceLow       = 0;
        o.oeLow       = 0;
        o.weLow       = 0;
        o.ubLow       = 0;
        o.lbLow       = 0;
        o.otherAcks   = 0;
        o.ceAtAck     = 1'b0;
        o.dataAtAck   = 16'h0000;
        o.ackAfter    = 1'b0;
        o.drivenAfter = 1'b0;
        @(negedge clock);
        if (port) begin
            aReq1 = 1'b1; aWe1 = we; aBe1 = be; aAddr1 = addr; aWdata1 = wdata;
        end else begin
            aReq0 = 1'b1; aWe0 = we; aBe0 = be; aAddr0 = addr; aWdata0 = wdata;
        end
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (!aCe)  o.ceLow++;
            if (!aOe)  o.oeLow++;
            if (!aWeN) o.weLow++;
            if (!aUb)  o.ubLow++;
            if (!aLb)  o.lbLow++;
            if (port ? aAck0 : aAck1) o.otherAcks++;
            if (port ? aAck1 : aAck0) begin
                o.ackCycle  = n;
                o.ceAtAck   = aCe;
                o.dataAtAck = aData;
                aReq0 = 1'b0;
                aReq1 = 1'b0;
                break;
            end
        end
        aReq0 = 1'b0;
        aReq1 = 1'b0;
        @(negedge clock);
        o.ackAfter    = port ? aAck1 : aAck0;
        o.drivenAfter = (aData === wdata);
    endtask

    initial begin
        obs_t        o;
        logic [3:0]  order;
        int          ackTimes [0:3];
        int          ackIdx;
        int          lat;
        int          strayAcks;

        testCount = 0;
        failCount = 0;
        reset = 1'b1;
        aReq0 = 0; aReq1 = 0; aWe0 = 0; aWe1 = 0; aBe0 = 0; aBe1 = 0;
        aAddr0 = 0; aAddr1 = 0; aWdata0 = 0; aWdata1 = 0;
        bReq0 = 0; cReq0 = 0; tieReq1 = 0; tieWe = 0; tieBe = 0;
        bAddr0 = 0; cAddr0 = 0; tieAddr = 0; tieWdata = 0;

        repeat (2) @(negedge clock);
        checkOutput("resetStrobes", 32'({aCe, aOe, aWeN, aUb, aLb}), 32'h1F);
        checkOutput("resetAddr", 32'(aAddr), 32'h0);
        checkOutput("resetAcks", 32'({aAck0, aAck1}), 32'h0);
        checkOutput("resetRdata0", 32'(aRdata0), 32'h0);
        checkOutput("resetRdata1", 32'(aRdata1), 32'h0);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] single read, port 0");
        applyStimulus(1'b0, 1'b0, 2'b11, 20'h00123, 16'h0000, o);
        checkOutput("rdAckCycle", 32'(o.ackCycle), 32'd3);
        checkOutput("rdCeLow", 32'(o.ceLow), 32'd2);
        checkOutput("rdOeLow", 32'(o.oeLow), 32'd2);
        checkOutput("rdWeLow", 32'(o.weLow), 32'd0);
        checkOutput("rdOtherAck", 32'(o.otherAcks), 32'd0);
        checkOutput("rdCeInDone", 32'(o.ceAtAck), 32'd1);
        checkOutput("rdAckPulse", 32'(o.ackAfter), 32'd0);
        checkOutput("rdData0", 32'(aRdata0), 32'hBEEF);

        $display("[TB] full write, port 1");
        applyStimulus(1'b1, 1'b1, 2'b11, 20'h00040, 16'h5A5A, o);
        checkOutput("wrAckCycle", 32'(o.ackCycle), 32'd3);
        checkOutput("wrWeLow", 32'(o.weLow), 32'd2);
        checkOutput("wrOeLow", 32'(o.oeLow), 32'd0);
        checkOutput("wrOtherAck", 32'(o.otherAcks), 32'd0);
        checkOutput("wrDataInDone", 32'(o.dataAtAck), 32'h5A5A);
        checkOutput("wrReleased", 32'(o.drivenAfter), 32'd0);
        checkOutput("wrMem", 32'(memA[8'h40]), 32'h5A5A);
        checkOutput("wrRdata1Kept", 32'(aRdata1), 32'h0);

        $display("[TB] upper-byte write, port 1");
        applyStimulus(1'b1, 1'b1, 2'b10, 20'h00040, 16'h1234, o);
        checkOutput("ubWrUbLow", 32'(o.ubLow), 32'd2);
        checkOutput("ubWrLbLow", 32'(o.lbLow), 32'd0);
        checkOutput("ubWrMem", 32'(memA[8'h40]), 32'h125A);

        applyStimulus(1'b1, 1'b0, 2'b11, 20'h00040, 16'h0000, o);
        checkOutput("rdBackAck", 32'(o.ackCycle), 32'd3);
        checkOutput("rdBackData1", 32'(aRdata1), 32'h125A);
        checkOutput("rdata0Held", 32'(aRdata0), 32'hBEEF);

        $display("[TB] contention, both ports held");
        @(negedge clock);
        aReq0 = 1'b1; aWe0 = 1'b0; aBe0 = 2'b11; aAddr0 = 20'h00123;
        aReq1 = 1'b1; aWe1 = 1'b0; aBe1 = 2'b11; aAddr1 = 20'h00040;
        order  = 4'b0000;
        ackIdx = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clock);
            if (aAck0 || aAck1) begin
                order = {order[2:0], aAck1};
                ackTimes[ackIdx] = n;
                ackIdx++;
                if (ackIdx == 4) break;
            end
        end
        aReq0 = 1'b0;
        aReq1 = 1'b0;
        checkOutput("ctAckCount", 32'(ackIdx), 32'd4);
        checkOutput("ctOrder", 32'(order), 32'b0101);
        checkOutput("ctFirstAck", 32'(ackTimes[0]), 32'd3);
        for (int i = 1; i < 4; i++) begin
            checkOutput("ctSpacing", 32'(ackTimes[i] - ackTimes[i-1]), 32'd4);
        end
        repeat (2) @(negedge clock);

        $display("[TB] reset during write access");
        aReq0 = 1'b1; aWe0 = 1'b1; aBe0 = 2'b11; aAddr0 = 20'h00050; aWdata0 = 16'hCAFE;
        @(negedge clock);
        checkOutput("rstWeActive", 32'(aWeN), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("rstStrobes", 32'({aCe, aOe, aWeN, aUb, aLb}), 32'h1F);
        checkOutput("rstReleased", 32'(aData === 16'hCAFE), 32'd0);
        aReq0 = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        strayAcks = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clock);
            if (aAck0 || aAck1) strayAcks++;
        end
        checkOutput("rstNoAck", 32'(strayAcks), 32'd0);
        applyStimulus(1'b0, 1'b1, 2'b11, 20'h00050, 16'hCAFE, o);
        checkOutput("reissueAck", 32'(o.ackCycle), 32'd3);
        checkOutput("reissueMem", 32'(memA[8'h50]), 32'hCAFE);
        applyStimulus(1'b0, 1'b0, 2'b11, 20'h00050, 16'h0000, o);
        checkOutput("reissueRead", 32'(aRdata0), 32'hCAFE);

        $display("[TB] latency, WAIT_CYCLES=1");
        @(negedge clock);
        bReq0 = 1'b1; bAddr0 = 20'h00077;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (bAck0) begin
                lat = n;
                break;
            end
        end
        bReq0 = 1'b0;
        checkOutput("w1Latency", 32'(lat), 32'd2);
        checkOutput("w1Rdata", 32'(bRdata0), 32'hA5B4);

        $display("[TB] latency, WAIT_CYCLES=15");
        @(negedge clock);
        cReq0 = 1'b1; cAddr0 = 20'h00300;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (cAck0) begin
                lat = n;
                break;
            end
        end
        cReq0 = 1'b0;
        checkOutput("w15Latency", 32'(lat), 32'd16);
        checkOutput("w15Rdata", 32'(cRdata0), 32'hA6C3);

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port controller that shares the single off-chip asynchronous SRAM between the SLC-3 CPU memory interface (port 0) and a secondary requester such as the program loader or debug/display scanner (port 1). It sits between both requesters and the physical SRAM pins, arbitrating round-robin and sequencing every access through a fixed multi-cycle strobe pattern. It owns the bidirectional data bus and drives it only during write cycles.

## Interface
- ADDR_W, 20, SRAM address width
- DATA_W, 16, SRAM data width
- WAIT_CYCLES, 2, strobe-active cycles per access (legal range 1–15)

- Clk  input  1  system clock; all state changes on rising edge
- Reset  input  1  asynchronous, active-high; already synchronised upstream
- req0 / req1  input  1  access request, held high until matching ack
- we0 / we1  input  1  1 = write, 0 = read; stable while req high
- be0 / be1  input  2  byte enables, [1] = upper, [0] = lower
- addr0 / addr1  input  ADDR_W  word address; stable while req high
- wdata0 / wdata1  input  DATA_W  write data; stable while req high
- ack0 / ack1  output  1  one-cycle completion pulse
- rdata0 / rdata1  output  DATA_W  read data, valid in ack cycle and held until next completion on that port
- CE, UB, LB, OE, WE  output  1 each  SRAM strobes, active-low
- ADDR  output  ADDR_W  SRAM address
- Data  inout  DATA_W  SRAM data bus

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: if any req high, latch winner's we/be/addr/wdata into internal registers, record grant, load wait counter with WAIT_CYCLES−1, go to ACCESS. Otherwise stay.
- Arbitration: one requester → it wins. Both → port not granted last time wins. last_grant resets to 1, so port 0 wins the first tie.
- ACCESS: CE=0; UB=~be[1], LB=~be[0]; ADDR = latched addr. Read: OE=0, WE=1, Data hi-Z. Write: OE=1, WE=0, Data driven with latched wdata. Counter decrements each cycle. On count 0, a read captures Data into rdata of the granted port and the block goes to DONE.
- DONE: all strobes inactive (CE, OE, WE, UB, LB = 1). Write data stays driven this cycle for hold time. ADDR is held. ack of granted port = 1. Next state is IDLE unconditionally; this is the bus-turnaround cycle.
- Requester dropping req during ACCESS is a protocol violation. The access still completes and ack still pulses.
- rdata of the non-granted port never changes. Writes do not modify rdata.
- be = 2'b00 still runs a full cycle with UB=LB=1, then acks.

## Timing
- Reset values (asynchronous): state IDLE; CE=OE=WE=UB=LB=1; ADDR=0; Data hi-Z; ack0=ack1=0; rdata0=rdata1=0; last_grant=1; counter 0.
- Reset mid-access: strobes go inactive and Data is released immediately. No ack is issued; the requester must re-request.
- Latency: req sampled high in IDLE at edge k → ACCESS for cycles k+1 … k+WAIT_CYCLES → ack high in cycle k+WAIT_CYCLES+1.
- Throughput: one access per WAIT_CYCLES+2 cycles. Back-to-back alternating grants occur under continuous contention.
- Requester may lower req in the cycle after ack. If req stays high after ack, it is treated as a new request in the next IDLE.
- All SRAM outputs are registered; no combinational path from req to pins.

## Structure
- Package sram_pkg holds:
  - the state enum typedef (IDLE/ACCESS/DONE)
  - a request struct typedef (we, be, addr, wdata)
  - the default ADDR_W and DATA_W constants
- Sub-module rr_arbiter2 covers round-robin grant plus last_grant register; it is combinational grant with registered history, updated only on IDLE→ACCESS.
- Tristate driver (Data = drive_en ? wdata_q : 'Z) lives in sram_arbiter.

## Test plan
- Single read, WAIT_CYCLES=2: port 0 reads addr 0x00123 with SRAM model holding 0xBEEF → OE/CE low for exactly 2 cycles, ack0 in 3rd cycle after req, rdata0=0xBEEF, ack1 never pulses.
- Single write: port 1 writes 0x5A5A to 0x00040, be=2'b11 → WE low 2 cycles, Data driven through DONE then hi-Z, model reads 0x5A5A; be=2'b10 writes upper byte only (LB stays 1).
- Contention: req0 and req1 raised in the same cycle and held → grants alternate 0,1,0,1; acks 4 cycles apart; no port acked twice in a row.
- Async reset mid-ACCESS of a write → strobes = 1 and Data hi-Z in the same cycle, no ack. After release, a re-issued request completes normally.
- Parameter sweep WAIT_CYCLES=1 and 15 → ack at k+2 and k+16 respectively. rdata0 holds its value across an intervening port-1 access.
